alu_mul_sequencer: RTL and testbench



---
 rtl/alu_mul_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-add 8x8 unsigned multiplier that drives the datapath ALU to do its additions.
// ALU_MUL_SKIP_ZERO_EN: when defined, bits whose multiplier bit is 0 skip the CLRC/ADD steps.
module alu_mul_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_funsel,
  input  logic [7:0]  alu_out,
  input  logic [3:0]  alu_flags
);

  // state   | meaning
  // IDLE    | waiting for start, ALU driven with zeros
  // CLRC    | LSL of 0x00 so the ALU carry is clear before the ADD
  // ADD     | ALU adds PH and (PL[0] ? M : 0)
  // SHIFT   | shift {C, PH, PL} right by one, advance bit counter
  // DONE    | product valid, one-cycle done pulse
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLRC  = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] FUN_NOP = 4'b0000;
  localparam logic [3:0] FUN_ADD = 4'b0100;
  localparam logic [3:0] FUN_LSL = 4'b1011;

  logic [2:0]  state_q, state_nx;
  logic [7:0]  m_q, m_nx;
  logic [7:0]  ph_q, ph_nx;
  logic [7:0]  pl_q, pl_nx;
  logic        c_q, c_nx;
  logic [2:0]  cnt_q, cnt_nx;
  logic [15:0] product_nx;
  logic        busy_nx, done_nx;
  logic [7:0]  alu_a_nx, alu_b_nx;
  logic [3:0]  alu_funsel_nx;

  always_comb begin
    state_nx   = state_q;
    m_nx       = m_q;
    ph_nx      = ph_q;
    pl_nx      = pl_q;
    c_nx       = c_q;
    cnt_nx     = cnt_q;
    product_nx = product;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_nx   = op_a;
          ph_nx  = 8'h00;
          pl_nx  = op_b;
          c_nx   = 1'b0;
          cnt_nx = 3'd0;
`ifdef ALU_MUL_SKIP_ZERO_EN
          state_nx = op_b[0] ? S_CLRC : S_SHIFT;
`else
          state_nx = S_CLRC;
`endif
        end
      end
      S_CLRC: state_nx = S_ADD;
      S_ADD: begin
        ph_nx    = alu_out;
        c_nx     = alu_flags[2];
        state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        ph_nx  = {c_q, ph_q[7:1]};
        pl_nx  = {ph_q[0], pl_q[7:1]};
        c_nx   = 1'b0;
        cnt_nx = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_nx   = S_DONE;
          product_nx = {c_q, ph_q[7:1], ph_q[0], pl_q[7:1]};
        end else begin
`ifdef ALU_MUL_SKIP_ZERO_EN
          state_nx = pl_q[1] ? S_CLRC : S_SHIFT;
`else
          state_nx = S_CLRC;
`endif
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ALU controls are decoded from the next state so they leave a register.
  always_comb begin
    alu_funsel_nx = FUN_NOP;
    alu_a_nx      = 8'h00;
    alu_b_nx      = 8'h00;
    case (state_nx)
      S_CLRC: alu_funsel_nx = FUN_LSL;
      S_ADD: begin
        alu_funsel_nx = FUN_ADD;
        alu_a_nx      = ph_nx;
        alu_b_nx      = pl_nx[0] ? m_nx : 8'h00;
      end
      default: alu_funsel_nx = FUN_NOP;
    endcase
    busy_nx = (state_nx == S_CLRC) || (state_nx == S_ADD) || (state_nx == S_SHIFT);
    done_nx = (state_nx == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      m_q        <= 8'h00;
      ph_q       <= 8'h00;
      pl_q       <= 8'h00;
      c_q        <= 1'b0;
      cnt_q      <= 3'd0;
      product    <= 16'h0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_funsel <= FUN_NOP;
    end else begin
      state_q    <= state_nx;
      m_q        <= m_nx;
      ph_q       <= ph_nx;
      pl_q       <= pl_nx;
      c_q        <= c_nx;
      cnt_q      <= cnt_nx;
      product    <= product_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      alu_a      <= alu_a_nx;
      alu_b      <= alu_b_nx;
      alu_funsel <= alu_funsel_nx;
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer with a behavioural ALU whose ADD uses a stored carry-in.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  op_a = 8'h00;
  logic [7:0]  op_b = 8'h00;
  logic        busy, done;
  logic [15:0] product;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [3:0]  alu_funsel, alu_flags;

  alu_mul_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_funsel(alu_funsel),
    .alu_out(alu_out), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  // ALU model: ADD is A+B+carry_in, LSL shifts A left; both latch their carry-out.
  logic alu_c_q;
  logic alu_cy;
  always_comb begin
    alu_out = 8'h00;
    alu_cy  = alu_c_q;
    case (alu_funsel)
      4'b0100: {alu_cy, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_c_q};
      4'b1011: {alu_cy, alu_out} = {alu_a, 1'b0};
      default: begin
        alu_out = 8'h00;
        alu_cy  = alu_c_q;
      end
    endcase
    alu_flags = {(alu_out == 8'h00), alu_cy, alu_out[7], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_c_q <= 1'b0;
    else if (alu_funsel == 4'b0100 || alu_funsel == 4'b1011) alu_c_q <= alu_cy;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [7:0] b);
`ifdef ALU_MUL_SKIP_ZERO_EN
    return 8 + 2 * $countones(b);
`else
    return 24;
`endif
  endfunction

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Launches one multiply and measures edges from E0 until done is seen.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] prod, output int lat);
    logic busy_ok;
    wait_idle();
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    busy_ok = busy;
    @(negedge clk);
    start = 1'b0;
    op_a  = 8'h5A;
    op_b  = 8'hC3;
    lat   = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    prod = product;
    chk("busy_during_op", {31'd0, busy_ok}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("done_pulse_width", {31'd0, done}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_prod;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [15:0] prod;
    int lat;
    int n;
    logic seen_done;

    vecs[0] = '{8'h0F, 8'h0F, 16'h00E1};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'hAB, 8'h00, 16'h0000};
    vecs[3] = '{8'h80, 8'h01, 16'h0080};
    vecs[4] = '{8'h01, 8'hFF, 16'h00FF};
    vecs[5] = '{8'h12, 8'h34, 16'h03A8};
    vecs[6] = '{8'hA5, 8'h3C, 16'h26AC};

    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_alu_b", {24'd0, alu_b}, 32'd0);
    chk("rst_funsel", {28'd0, alu_funsel}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_mul(vecs[i].a, vecs[i].b, prod, lat);
      chk($sformatf("product_%0h_x_%0h", vecs[i].a, vecs[i].b), {16'd0, prod}, {16'd0, vecs[i].exp_prod});
      chk($sformatf("latency_%0h_x_%0h", vecs[i].a, vecs[i].b), lat, exp_latency(vecs[i].b));
    end

    // Reset in the middle of 0x12 x 0x34, ten edges after E0.
    wait_idle();
    start = 1'b1;
    op_a  = 8'h12;
    op_b  = 8'h34;
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_product", {16'd0, product}, 32'd0);
    chk("abort_funsel", {28'd0, alu_funsel}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    chk("abort_stays_idle", {31'd0, seen_done}, 32'd0);
    run_mul(8'h12, 8'h34, prod, lat);
    chk("after_abort_product", {16'd0, prod}, 32'h03A8);
    chk("after_abort_latency", lat, exp_latency(8'h34));

    // A second start five edges into 0x05 x 0x07 must be ignored.
    wait_idle();
    start = 1'b1;
    op_a  = 8'h05;
    op_b  = 8'h07;
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op_a  = 8'h09;
    op_b  = 8'h09;
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b0;
    n   = 5;
    lat = -1;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("overlap_product", {16'd0, product}, 32'h0023);
    chk("overlap_latency", lat, exp_latency(8'h07));
    seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    chk("overlap_no_second_op", {31'd0, seen_done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
